// File: rtl/fifo_stream_reader.sv
// Drains a CDC FIFO into a raster-tagged pixel stream through a 2-entry registered buffer.
// Handles FIFO read latency 0 (first-word fall-through) or 1 (standard).
module fifo_stream_reader #(
  parameter int DATA_W     = 8,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int RD_LATENCY = 1,
  parameter int STALL_W    = 16
) (
  input  logic               clk_200mhz,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [DATA_W-1:0]  fifo_dout,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  output logic [DATA_W-1:0]  pixel_out,
  output logic               valid_out,
  output logic               sof_out,
  output logic               eol_out,
  output logic               eof_out,
  input  logic               ready_in,
  output logic               frame_done,
  output logic [STALL_W-1:0] stall_cnt
);
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic [DATA_W-1:0]  buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]         count_q, count_d;
  logic               valid_q;
  logic               inflight_q;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic               frame_done_q;
  logic [STALL_W-1:0] stall_q;
  logic               xfer, push, at_eol, at_eof, at_origin;
  logic [2:0]         occ;

  assign xfer      = valid_q & ready_in;
  assign at_eol    = (x_q == X_LAST);
  assign at_eof    = at_eol & (y_q == Y_LAST);
  assign at_origin = (x_q == '0) & (y_q == '0);

  // Slots committed after this edge: buffered words plus the read still in flight.
  assign occ        = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, xfer};
  assign fifo_rd_en = enable & ~fifo_empty & (occ < 3'd2);
  assign push       = (RD_LATENCY == 0) ? fifo_rd_en : inflight_q;

  always_comb begin
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    count_d = count_q;
    case ({push, xfer})
      2'b10: begin
        if (count_q == 2'd0) buf0_d = fifo_dout;
        else                 buf1_d = fifo_dout;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) buf0_d = buf1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          buf0_d = fifo_dout;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_dout;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (xfer) begin
      x_d = at_eol ? '0 : x_q + XW'(1);
      if (at_eol) y_d = at_eof ? '0 : y_q + YW'(1);
    end
  end

  always_ff @(posedge clk_200mhz or negedge reset_n) begin
    if (!reset_n) begin
      buf0_q       <= '0;
      buf1_q       <= '0;
      count_q      <= 2'd0;
      valid_q      <= 1'b0;
      inflight_q   <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
      stall_q      <= '0;
    end else begin
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      count_q      <= count_d;
      valid_q      <= (count_d != 2'd0);
      inflight_q   <= (RD_LATENCY == 1) ? fifo_rd_en : 1'b0;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_done_q <= xfer & at_eof;
      // Only mid-frame starvation is interesting; idle between frames is not counted.
      if (ready_in & ~valid_q & ~at_origin & ~(&stall_q)) stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign pixel_out  = buf0_q;
  assign valid_out  = valid_q;
  assign sof_out    = valid_q & at_origin;
  assign eol_out    = valid_q & at_eol;
  assign eof_out    = valid_q & at_eof;
  assign frame_done = frame_done_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a latency-1 and a latency-0 instance share stimulus,
// each fed by its own FIFO model and checked against a shared expected-pixel scoreboard.
module tb_fifo_stream_reader;
  typedef struct packed {
    logic [7:0] pix;
    logic       sof;
    logic       eol;
    logic       eof;
  } exp_t;

  logic        clk, reset_n, enable, ready;
  logic [7:0]  d0, d1, p0, p1;
  logic        e0, e1, rd0, rd1, v0, v1, s0, s1, l0, l1, f0, f1, fd0, fd1;
  logic [15:0] st0, st1;

  logic [7:0]  mem [0:255];
  int          wp, rp0, rp1, pos;
  exp_t        sb0[$], sb1[$];

  int          n_chk, n_fail, cyc;
  int          occ[2], infl[2], mpos[2], xfer_n[2], fd_seen[2];
  int          first_rd[2], first_v[2], first_x[2], last_x[2];
  logic        fd_exp[2], hold[2];
  logic [7:0]  hpix[2];
  logic [15:0] st_exp[2];

  fifo_stream_reader #(.DATA_W(8), .IMG_W(4), .IMG_H(2), .RD_LATENCY(1), .STALL_W(16)) dut (
    .clk_200mhz(clk), .reset_n(reset_n), .enable(enable), .fifo_dout(d0), .fifo_empty(e0),
    .fifo_rd_en(rd0), .pixel_out(p0), .valid_out(v0), .sof_out(s0), .eol_out(l0),
    .eof_out(f0), .ready_in(ready), .frame_done(fd0), .stall_cnt(st0));

  fifo_stream_reader #(.DATA_W(8), .IMG_W(4), .IMG_H(2), .RD_LATENCY(0), .STALL_W(16)) dut_fwft (
    .clk_200mhz(clk), .reset_n(reset_n), .enable(enable), .fifo_dout(d1), .fifo_empty(e1),
    .fifo_rd_en(rd1), .pixel_out(p1), .valid_out(v1), .sof_out(s1), .eol_out(l1),
    .eof_out(f1), .ready_in(ready), .frame_done(fd1), .stall_cnt(st1));

  always #5 clk = ~clk;

  assign e0 = (rp0 == wp);
  assign e1 = (rp1 == wp);
  assign d1 = mem[rp1[7:0]];

  // Resetting the bench FIFOs along with the DUTs drops any unread words.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rp0 <= wp;
      d0  <= 8'h00;
    end else if (rd0) begin
      d0  <= mem[rp0[7:0]];
      rp0 <= rp0 + 1;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rp1 <= wp;
    else if (rd1) rp1 <= rp1 + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic mon(input int i, input logic rd, input logic em, input logic v,
                     input logic [7:0] pix, input logic sof, input logic eol, input logic eof,
                     input logic fd, input logic [15:0] st);
    exp_t e;
    logic xf, push;
    int   qs;
    if (!reset_n) begin
      occ[i] = 0; infl[i] = 0; mpos[i] = 0; xfer_n[i] = 0; fd_seen[i] = 0;
      first_rd[i] = -1; first_v[i] = -1; first_x[i] = -1; last_x[i] = -1;
      fd_exp[i] = 1'b0; hold[i] = 1'b0; st_exp[i] = 16'd0;
      if (i == 0) sb0.delete(); else sb1.delete();
      return;
    end
    xf = v & ready;
    check_val($sformatf("rd_en%0d", i), rd,
              enable & ~em & ((occ[i] + infl[i] - int'(xf)) < 2));
    check_val($sformatf("valid%0d", i), v, occ[i] != 0);
    check_val($sformatf("frame_done%0d", i), fd, fd_exp[i]);
    check_val($sformatf("stall%0d", i), st, st_exp[i]);
    if (hold[i]) check_val($sformatf("hold_pix%0d", i), pix, hpix[i]);
    if (fd) fd_seen[i]++;
    qs = (i == 0) ? sb0.size() : sb1.size();
    e  = '0;
    if (!v) begin
      check_val($sformatf("flags_idle%0d", i), {sof, eol, eof}, 3'b000);
    end else if (qs == 0) begin
      check_val($sformatf("unexpected_pix%0d", i), 1, 0);
    end else begin
      e = (i == 0) ? sb0[0] : sb1[0];
      check_val($sformatf("pix%0d", i), pix, e.pix);
      check_val($sformatf("flags%0d", i), {sof, eol, eof}, {e.sof, e.eol, e.eof});
      if (xf) begin
        if (i == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
        xfer_n[i]++;
        if (first_x[i] < 0) first_x[i] = cyc;
        last_x[i] = cyc;
      end
    end
    fd_exp[i] = xf & e.eof;
    if (ready && !v && mpos[i] != 0 && st_exp[i] != 16'hffff) st_exp[i]++;
    if (xf) mpos[i] = (mpos[i] + 1) % 8;
    hold[i] = v & ~ready;
    hpix[i] = pix;
    push = (i == 0) ? (infl[i] != 0) : rd;
    if (push) check_val($sformatf("buf_overflow%0d", i), (occ[i] - int'(xf)) < 2, 1);
    occ[i]  = occ[i] + int'(push) - int'(xf);
    infl[i] = (i == 0) ? int'(rd) : 0;
    if (rd && first_rd[i] < 0) first_rd[i] = cyc;
    if (v && first_v[i] < 0) first_v[i] = cyc;
  endtask

  always @(negedge clk) begin
    cyc++;
    mon(0, rd0, e0, v0, p0, s0, l0, f0, fd0, st0);
    mon(1, rd1, e1, v1, p1, s1, l1, f1, fd1, st1);
  end

  task automatic load(input int n, input logic [7:0] first);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.pix = first + 8'(k);
      e.sof = (pos == 0);
      e.eol = ((pos % 4) == 3);
      e.eof = (pos == 7);
      mem[wp[7:0]] = e.pix;
      sb0.push_back(e);
      sb1.push_back(e);
      pos = (pos + 1) % 8;
      wp++;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; enable = 1'b0; ready = 1'b0; pos = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int k = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && k < budget) begin
      @(posedge clk); #1; k++;
    end
    check_val(tag, (sb0.size() == 0) && (sb1.size() == 0), 1);
  endtask

  task automatic wait_xfer(input int n, input string tag);
    int k = 0;
    while (xfer_n[0] < n && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check_val(tag, xfer_n[0] >= n, 1);
  endtask

  initial begin
    clk = 1'b0; n_chk = 0; n_fail = 0; cyc = 0; wp = 0; pos = 0;
    reset_n = 1'b0; enable = 1'b0; ready = 1'b0;
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
    do_reset();
    @(posedge clk); #1;
    check_val("rst_outs0", {v0, s0, l0, f0, fd0, p0, st0}, '0);
    check_val("rst_outs1", {v1, s1, l1, f1, fd1, p1, st1}, '0);

    // Streaming, and FWFT latency on the second instance
    load(8, 8'h01);
    @(posedge clk); #1;
    enable = 1'b1; ready = 1'b1;
    wait_drain(40, "drain_stream");
    repeat (3) @(posedge clk); #1;
    check_val("burst_len0", last_x[0] - first_x[0], 7);
    check_val("burst_len1", last_x[1] - first_x[1], 7);
    check_val("latency_rl1", first_v[0] - first_rd[0], 2);
    check_val("latency_rl0", first_v[1] - first_rd[1], 1);
    check_val("fd_count0", fd_seen[0], 1);
    check_val("fd_count1", fd_seen[1], 1);
    check_val("stall_zero0", st0, 0);

    // Backpressure 1,0,0,...
    do_reset();
    load(8, 8'h01);
    enable = 1'b1;
    for (int k = 0; k < 120 && (sb0.size() != 0 || sb1.size() != 0); k++) begin
      ready = (k % 3 == 0);
      @(posedge clk); #1;
    end
    check_val("drain_bp", (sb0.size() == 0) && (sb1.size() == 0), 1);
    ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check_val("bp_count0", xfer_n[0], 8);
    check_val("bp_count1", xfer_n[1], 8);

    // Starvation mid-line
    do_reset();
    load(3, 8'h01);
    enable = 1'b1; ready = 1'b1;
    wait_drain(20, "drain_starve_a");
    repeat (5) @(posedge clk); #1;
    load(5, 8'h04);
    wait_drain(30, "drain_starve_b");
    repeat (2) @(posedge clk); #1;
    check_val("stall_ge5_0", st0 >= 16'd5, 1);
    check_val("stall_ge5_1", st1 >= 16'd5, 1);

    // Asynchronous reset mid-frame
    do_reset();
    load(8, 8'h01);
    enable = 1'b1; ready = 1'b1;
    wait_xfer(2, "reach_x2");
    @(negedge clk); #2 reset_n = 1'b0;
    #1;
    check_val("async_rst0", {v0, s0, l0, f0, fd0, p0, st0, rd0}, '0);
    check_val("async_rst1", {v1, s1, l1, f1, fd1, p1, st1, rd1}, '0);
    enable = 1'b0; ready = 1'b0; pos = 0;
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    load(8, 8'h41);
    enable = 1'b1; ready = 1'b1;
    wait_drain(40, "drain_after_rst");
    repeat (3) @(posedge clk); #1;
    check_val("fd_after_rst0", fd_seen[0], 1);

    // Enable drop mid-line, then three frames
    do_reset();
    load(8, 8'h01);
    enable = 1'b1; ready = 1'b1;
    wait_xfer(2, "reach_x2b");
    enable = 1'b0;
    repeat (6) @(posedge clk); #1;
    check_val("en_drop_valid0", v0, 0);
    check_val("en_drop_valid1", v1, 0);
    check_val("en_drop_kept", (wp - rp0) > 0, 1);
    enable = 1'b1;
    load(16, 8'h09);
    wait_drain(100, "drain_3frames");
    repeat (3) @(posedge clk); #1;
    check_val("wrap_fd0", fd_seen[0], 3);
    check_val("wrap_fd1", fd_seen[1], 3);
    check_val("wrap_xfer0", xfer_n[0], 24);
    check_val("wrap_xfer1", xfer_n[1], 24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
